pipelined_adder_nbit: RTL and testbench

Parametrised, pipelined add/subtract unit: next-generation replacement for the single-cycle 32-bit full adder. Splits a WIDTH-bit operation into STAGES equal chunks, each computing one chunk-wide addition per cycle with the carry registered between stages. Sustains one operation per clock behind a valid/ready handshake, and reports carry, signed overflow and zero flags. Sits between operand-issue logic and a result consumer that may apply backpressure.

---
 rtl/adder_pkg.sv | 24 ++
 rtl/adder_pipe_stage.sv | 41 ++++
 rtl/pipelined_adder_nbit.sv | 151 +++++++++++++++
 tb/tb_pipelined_adder_nbit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit:
// op encoding, chunk width and signed saturation bounds.
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Widest operand the saturation helpers can describe; callers cast down to WIDTH.
    localparam int MAX_WIDTH = 1024;
    typedef logic [MAX_WIDTH-1:0] wide_t;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic wide_t sat_min(input int width);
        return wide_t'(1) << (width - 1);
    endfunction

    function automatic wide_t sat_max(input int width);
        return sat_min(width) - wide_t'(1);
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// One chunk of the pipelined adder: a CH-bit add whose sum, carry-out,
// signed-overflow bit and stage valid are registered together.
module adder_pipe_stage #(
    parameter int CH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          valid,
    input  logic [CH-1:0] a,
    input  logic [CH-1:0] b,
    input  logic          cin,
    output logic          valid_q,
    output logic [CH-1:0] sum_q,
    output logic          cout_q,
    output logic          ovf_q
);

    logic [CH:0] total;
    logic        msb_carry;

    assign total     = {1'b0, a} + {1'b0, b} + {{CH{1'b0}}, cin};
    // Carry into the chunk's top bit; only the most significant chunk's overflow is consumed.
    assign msb_carry = a[CH-1] ^ b[CH-1] ^ total[CH-1];

    // NOTE: state updates use <= so every flop samples pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (en) begin
            valid_q <= valid;
            sum_q   <= total[CH-1:0];
            cout_q  <= total[CH];
            ovf_q   <= msb_carry ^ total[CH];
        end
    end

endmodule

// File: rtl/pipelined_adder_nbit.sv
// Pipelined WIDTH-bit add/subtract unit, STAGES chunks deep, with valid/ready flow control
// and carry/overflow/zero flags. Define ADDER_SATURATE_EN to build the sat_i clamp path.
module pipelined_adder_nbit
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] Y_i,
    input  logic             C_i,
    input  logic             sub_i,
`ifdef ADDER_SATURATE_EN
    input  logic             sat_i,
`endif
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] Sum_o,
    output logic             c_o,
    output logic             ovf_o,
    output logic             zero_o
);

    localparam int CH = chunk_width(WIDTH, STAGES);

    logic             advance;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] a_skew_q    [STAGES];
    logic [WIDTH-1:0] b_skew_q    [STAGES];
    logic [WIDTH-1:0] low_q       [STAGES];
    logic [WIDTH-1:0] done        [STAGES];
    logic [CH-1:0]    chunk_sum   [STAGES];
    logic             chunk_cout  [STAGES];
    logic             chunk_ovf   [STAGES];
    logic             chunk_valid [STAGES];
    logic [WIDTH-1:0] final_sum;

    // A result held by the consumer freezes every stage, bubbles included.
    assign advance = !(valid_o && !ready_i);
    assign ready_o = advance;
    assign b_in    = (sub_i == OP_SUB) ? ~Y_i : Y_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CH-1:0] a_chunk;
        logic [CH-1:0] b_chunk;
        logic          cin;
        logic          vin;

        if (k == 0) begin : g_first
            assign a_chunk = A_i[CH-1:0];
            assign b_chunk = b_in[CH-1:0];
            assign cin     = C_i;
            assign vin     = valid_i;
        end else begin : g_rest
            assign a_chunk = a_skew_q[k-1][k*CH +: CH];
            assign b_chunk = b_skew_q[k-1][k*CH +: CH];
            assign cin     = chunk_cout[k-1];
            assign vin     = chunk_valid[k-1];
        end

        adder_pipe_stage #(.CH(CH)) u_stage (
            .clk     (clk_i),
            .rst_n   (rst_ni),
            .en      (advance),
            .valid   (vin),
            .a       (a_chunk),
            .b       (b_chunk),
            .cin     (cin),
            .valid_q (chunk_valid[k]),
            .sum_q   (chunk_sum[k]),
            .cout_q  (chunk_cout[k]),
            .ovf_q   (chunk_ovf[k])
        );
    end

    // done[k] is the result word with chunks 0..k valid, aligned to stage k's output.
    // NOTE: every always_comb target gets a full assignment before any partial one, so no latch is inferred.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            done[k]              = low_q[k];
            done[k][k*CH +: CH]  = chunk_sum[k];
        end
    end

    // NOTE: the skew/deskew words are ordinary flops, not a RAM, so they are cleared like any other state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) begin
                a_skew_q[k] <= '0;
                b_skew_q[k] <= '0;
                low_q[k]    <= '0;
            end
        end else if (advance) begin
            a_skew_q[0] <= A_i;
            b_skew_q[0] <= b_in;
            low_q[0]    <= '0;
            for (int k = 1; k < STAGES; k++) begin
                a_skew_q[k] <= a_skew_q[k-1];
                b_skew_q[k] <= b_skew_q[k-1];
                low_q[k]    <= done[k-1];
            end
        end
    end

`ifdef ADDER_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_MAX = WIDTH'(sat_max(WIDTH));
    localparam logic [WIDTH-1:0] SAT_MIN = WIDTH'(sat_min(WIDTH));

    logic sat_q [STAGES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) sat_q[k] <= 1'b0;
        end else if (advance) begin
            sat_q[0] <= sat_i;
            for (int k = 1; k < STAGES; k++) sat_q[k] <= sat_q[k-1];
        end
    end

    // A wrapped result with MSB set came from positive overflow, and vice versa.
    always_comb begin
        final_sum = done[STAGES-1];
        if (sat_q[STAGES-1] && chunk_ovf[STAGES-1]) begin
            final_sum = done[STAGES-1][WIDTH-1] ? SAT_MAX : SAT_MIN;
        end
    end
`else
    assign final_sum = done[STAGES-1];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            Sum_o   <= '0;
            c_o     <= 1'b0;
            ovf_o   <= 1'b0;
            zero_o  <= 1'b0;
        end else if (advance) begin
            valid_o <= chunk_valid[STAGES-1];
            Sum_o   <= final_sum;
            c_o     <= chunk_cout[STAGES-1];
            ovf_o   <= chunk_ovf[STAGES-1];
            zero_o  <= (final_sum == '0);
        end
    end

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// Scoreboard bench for pipelined_adder_nbit (WIDTH 32, STAGES 4): expected results are queued at
// accept time and compared as each result transfers out.
module tb_pipelined_adder_nbit;
    import adder_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        c;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] A_i;
    logic [31:0] Y_i;
    logic        C_i;
    logic        sub_i;
`ifdef ADDER_SATURATE_EN
    logic        sat_i;
`endif
    logic        valid_o;
    logic        ready_i;
    logic [31:0] Sum_o;
    logic        c_o;
    logic        ovf_o;
    logic        zero_o;

    int   checks = 0;
    int   errors = 0;
    res_t sb[$];

    pipelined_adder_nbit #(.WIDTH(32), .STAGES(4)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .A_i     (A_i),
        .Y_i     (Y_i),
        .C_i     (C_i),
        .sub_i   (sub_i),
`ifdef ADDER_SATURATE_EN
        .sat_i   (sat_i),
`endif
        .valid_o (valid_o),
        .ready_i (ready_i),
        .Sum_o   (Sum_o),
        .c_o     (c_o),
        .ovf_o   (ovf_o),
        .zero_o  (zero_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic res_t mk(input logic [31:0] sum, input logic c, input logic ovf);
        res_t r;
        r.sum  = sum;
        r.c    = c;
        r.ovf  = ovf;
        r.zero = (sum == 32'd0);
        return r;
    endfunction

    // Reference: overflow from operand/result signs, clamp direction from operand sign.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                   input logic sub, input logic sat);
        logic [31:0] bb;
        logic [32:0] t;
        res_t        r;
        bb    = sub ? ~b : b;
        t     = {1'b0, a} + {1'b0, bb} + {32'd0, cin};
        r.sum = t[31:0];
        r.c   = t[32];
        r.ovf = (a[31] == bb[31]) && (t[31] != a[31]);
        if (sat && r.ovf) r.sum = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        r.zero = (r.sum == 32'd0);
        return r;
    endfunction

    // Called at posedge+2; returns at posedge+2 just after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input logic sub, input res_t exp);
        int n;
        A_i = a; Y_i = b; C_i = cin; sub_i = sub; valid_i = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!ready_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        check("accept_ready", 32'(ready_o), 32'd1);
        if (ready_o) sb.push_back(exp);
        @(posedge clk_i);
        #2;
        valid_i = 1'b0;
    endtask

    // Lone beat into an empty pipe: valid_o must rise exactly 4 edges after the accept edge.
    task automatic latency_beat(input logic [31:0] a, input logic [31:0] b, input logic cin,
                                input logic sub, input res_t exp);
        send(a, b, cin, sub, exp);
        repeat (4) @(negedge clk_i);
        check("latency_early", 32'(valid_o), 32'd0);
        @(negedge clk_i);
        check("latency_on_time", 32'(valid_o), 32'd1);
        @(posedge clk_i);
        #2;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, 32'(sb.size()), 32'd0);
        @(posedge clk_i);
        #2;
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check("spurious_result", 32'(valid_o), 32'd0);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("sum",  Sum_o,         e.sum);
                check("c_o",  32'(c_o),      32'(e.c));
                check("ovf",  32'(ovf_o),    32'(e.ovf));
                check("zero", 32'(zero_o),   32'(e.zero));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        int          n;
        logic [31:0] held;

        rst_ni = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        A_i = '0; Y_i = '0; C_i = 1'b0; sub_i = OP_ADD;
`ifdef ADDER_SATURATE_EN
        sat_i = 1'b0;
`endif
        #1 rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_sum",   Sum_o,        32'd0);
        check("rst_c",     32'(c_o),     32'd0);
        check("rst_ovf",   32'(ovf_o),   32'd0);
        check("rst_zero",  32'(zero_o),  32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        repeat (10) begin
            @(negedge clk_i);
            check("idle_valid", 32'(valid_o), 32'd0);
        end
        @(posedge clk_i);
        #2;

        // Carry ripples through all four chunks.
        latency_beat(32'hFFFF_FFF0, 32'h0000_0010, 1'b0, OP_ADD, mk(32'h0000_0000, 1'b1, 1'b0));

        // Back-to-back beats at full rate.
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, mk(32'h8000_0000, 1'b0, 1'b1));
        send(32'h0000_0005, 32'h0000_0007, 1'b1, OP_SUB, mk(32'hFFFF_FFFE, 1'b0, 1'b0));
        send(32'hFFFF_FFFE, 32'h0000_0002, 1'b1, OP_ADD, mk(32'h0000_0001, 1'b1, 1'b0));
        drain("drain_b2b");

        // Backpressure: fill the pipe with ready_i low, hold, then release.
        ready_i = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    a = 32'h1000_0000 * i + i;
                    b = 32'h0000_0003 * i;
                    send(a, b, 1'b0, OP_ADD, model(a, b, 1'b0, OP_ADD, 1'b0));
                end
            end
            begin
                n = 0;
                while (!valid_o && n < 20) begin
                    @(negedge clk_i);
                    n++;
                end
                check("fill_valid", 32'(valid_o), 32'd1);
                held = Sum_o;
                repeat (3) begin
                    @(negedge clk_i);
                    check("stall_ready", 32'(ready_o), 32'd0);
                    check("stall_valid", 32'(valid_o), 32'd1);
                    check("stall_hold",  Sum_o,        held);
                end
                @(posedge clk_i);
                #2 ready_i = 1'b1;
            end
        join
        drain("drain_backpressure");

`ifdef ADDER_SATURATE_EN
        sat_i = 1'b1;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
        send(32'h8000_0000, 32'h0000_0001, 1'b1, OP_SUB, mk(32'h8000_0000, 1'b1, 1'b1));
        sat_i = 1'b0;
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, mk(32'h8000_0000, 1'b0, 1'b1));
        send(32'h8000_0000, 32'h0000_0001, 1'b1, OP_SUB, mk(32'h7FFF_FFFF, 1'b1, 1'b1));
        drain("drain_sat");
`endif

        // Random operands with random consumer stalls and issue gaps.
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    a   = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom);
                    b   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom);
                    cin = 1'($urandom);
                    sub = 1'($urandom);
`ifdef ADDER_SATURATE_EN
                    sat_i = 1'($urandom);
                    send(a, b, cin, sub, model(a, b, cin, sub, sat_i));
`else
                    send(a, b, cin, sub, model(a, b, cin, sub, 1'b0));
`endif
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk_i);
                        #2;
                    end
                end
            end
            begin
                repeat (40) begin
                    @(posedge clk_i);
                    #2 ready_i = ($urandom_range(0, 3) != 0);
                end
                ready_i = 1'b1;
            end
        join
        ready_i = 1'b1;
        drain("drain_random");

        // Asynchronous reset with three beats held in the pipe.
        ready_i = 1'b0;
        send(32'h0000_0011, 32'h0000_0022, 1'b0, OP_ADD, mk(32'h0000_0033, 1'b0, 1'b0));
        send(32'h0000_0044, 32'h0000_0055, 1'b0, OP_ADD, mk(32'h0000_0099, 1'b0, 1'b0));
        send(32'h0000_0100, 32'h0000_0001, 1'b1, OP_SUB, mk(32'h0000_00FF, 1'b1, 1'b0));
        n = 0;
        while (!valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        check("preflush_valid", 32'(valid_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_valid", 32'(valid_o), 32'd0);
        check("async_rst_sum",   Sum_o,        32'd0);
        check("async_rst_ready", 32'(ready_o), 32'd1);
        sb.delete();
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        ready_i = 1'b1;
        repeat (8) begin
            @(negedge clk_i);
            check("post_rst_idle", 32'(valid_o), 32'd0);
        end
        @(posedge clk_i);
        #2;
        latency_beat(32'h1234_5678, 32'h1111_1111, 1'b0, OP_ADD, mk(32'h2345_6789, 1'b0, 1'b0));
        drain("drain_final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
